onehot_bin_enc: RTL

Registered one-hot to binary encoder with a valid/ready handshake and code-error checking. It is the inverse of the team's binary to one-hot decoder. It sits at the receive end of one-hot select buses and returns the index as a binary code. It flags malformed codes (all-zero or multi-hot) per transfer and keeps a sticky flag and a saturating error count for debug.

---
 rtl/onehot_bin_enc.sv | 88 ++++++++
 1 files changed

// File: rtl/onehot_bin_enc.sv
// Registered one-hot to binary encoder with a one-entry output buffer.
// Malformed codes (all-zero or multi-hot) are flagged per transfer and tallied for debug.
module onehot_bin_enc #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] one_hot,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] bin,
    output logic         code_err,
    output logic         err_sticky,
    input  logic         err_clr,
    output logic [7:0]   err_cnt
);

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // Valid never waits on ready. in_ready depends only on the output register
    // state and out_ready, so it never combinationally depends on in_valid.
    logic         accept;
    logic         out_xfer;
    logic [W-1:0] enc_bin;
    logic         enc_zero;
    logic         enc_multi;
    logic         enc_err;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // Lowest set bit wins; scanning from the top lets lower bits overwrite.
    always_comb begin
        enc_bin = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (one_hot[k]) begin
                enc_bin = W'(k);
            end
        end
    end

    // x & (x - 1) clears the lowest set bit; anything left means multi-hot.
    assign enc_zero  = ~|one_hot;
    assign enc_multi = |(one_hot & (one_hot - N'(1)));
    assign enc_err   = enc_zero || enc_multi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            bin       <= '0;
            code_err  <= 1'b0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                bin       <= enc_bin;
                code_err  <= enc_err;
            end else if (out_xfer) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Clear is applied before the increment so a same-cycle error survives it.
    logic [7:0] cnt_base;
    logic       sticky_base;

    assign cnt_base    = err_clr ? 8'd0 : err_cnt;
    assign sticky_base = err_clr ? 1'b0 : err_sticky;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt    <= 8'd0;
            err_sticky <= 1'b0;
        end else begin
            if (accept && enc_err) begin
                err_sticky <= 1'b1;
                err_cnt    <= (cnt_base == 8'hFF) ? cnt_base : cnt_base + 8'd1;
            end else begin
                err_sticky <= sticky_base;
                err_cnt    <= cnt_base;
            end
        end
    end

endmodule
